bus_select_reg: RTL and testbench
=================================

Name: bus_select_reg

Overview:
- Parametrised, registered N-channel bus selector for the multicycle 16-bit RISC datapath.
- Successor to the fixed 8:1 16-bit combinational mux, generalised in WIDTH and CHANNELS.
- Adds a latched select register, a capture enable, selected-channel tagging and out-of-range detection.
- Adds an auto-incrementing scan mode used to sweep sources (register dump / debug bus monitor).

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 8, number of input channels; legal range 2..256.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  CHANNELS*WIDTH  packed channels; channel k occupies din[k*WIDTH +: WIDTH].
- sel  input  SEL_W  select value, used only when sel_ld=1.
- sel_ld  input  1  loads sel into sel_reg (DIRECT) or scan_ptr (SCAN).
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled every cycle.
- en  input  1  capture enable.
- dout  output  WIDTH  registered selected data.
- dout_sel  output  SEL_W  channel index that produced dout.
- dout_valid  output  1  one-cycle pulse per capture.
- sel_err  output  1  registered with dout; 1 when the captured index was >= CHANNELS.
- scan_wrap  output  1  one-cycle pulse when scan_ptr wraps from CHANNELS-1 to 0.

Behaviour:
- Reset (async, any time, including mid-scan):
  - dout = 0, dout_sel = 0, dout_valid = 0, sel_err = 0, scan_wrap = 0.
  - sel_reg = 0, scan_ptr = 0, state = DIRECT.
  - Deassertion is sampled at the first clk edge after rst falls.
- States: DIRECT, SCAN.
  - DIRECT -> SCAN when mode=1 at an edge. On that edge scan_ptr <= (sel_ld ? sel : sel_reg).
  - SCAN -> DIRECT when mode=0 at an edge. scan_ptr is retained but unused.
- Effective index idx:
  - DIRECT: idx = sel_ld ? sel : sel_reg. sel_reg <= sel when sel_ld=1.
  - SCAN: idx = sel_ld ? sel : scan_ptr.
  - A same-cycle load therefore takes effect in that capture; there is no extra bubble.
- Capture (en=1), latency 1 clk from inputs to outputs:
  - dout <= din channel idx.
  - dout_sel <= idx.
  - dout_valid <= 1.
  - sel_err <= (idx >= CHANNELS).
  - Out-of-range idx: dout <= 0 and dout_sel <= idx; no X propagation.
- Scan advance (SCAN state, en=1):
  - scan_ptr <= idx+1, or 0 when idx >= CHANNELS-1.
  - scan_wrap <= 1 only when idx == CHANNELS-1.
  - An out-of-range idx goes to 0 with scan_wrap = 0 and sel_err = 1.
- en=0:
  - dout, dout_sel and sel_err hold.
  - dout_valid <= 0, scan_wrap <= 0.
  - scan_ptr does not advance; sel_ld still loads sel_reg / scan_ptr.
- Entry edge: the mode-change edge itself performs no capture or advance in the new mode. Captures and advances in SCAN start on the next edge with en=1.
- din is sampled only at capture edges; it may change freely otherwise.
- Output is purely registered; no combinational path from din, sel or en to any output.

Test Plan:
- Reset/DIRECT sweep: channel k = 16'h1000+k. Apply rst, then deassert; outputs are 0. For sel=0..7, apply sel_ld=1 and en=1 for one cycle each. Next cycle: dout = 16'h1000+sel, dout_sel = sel, dout_valid = 1 for one cycle, sel_err = 0.
- Hold: after capturing sel=5, apply en=0 for 4 cycles while changing din and sel (sel_ld=0). dout stays 16'h1005 and dout_valid = 0. Then en=1 with sel_ld=0: dout = the new channel-5 value, confirming sel_reg was retained.
- SCAN wrap: sel=6 with sel_ld=1 and mode=1 on the same edge, then en=1 for 4 cycles. dout sequence is 16'h1006, 16'h1007, 16'h1000, 16'h1001. scan_wrap pulses exactly with the 16'h1007 capture.
- Out-of-range: CHANNELS=5, SEL_W=3, sel=6 with en=1 in DIRECT. Result: dout = 0, dout_sel = 6, sel_err = 1. The next capture with sel=2 clears sel_err and gives dout = 16'h1002.
- Reset mid-scan: assert rst asynchronously between edges during a SCAN sweep. All outputs go to 0 immediately, without waiting for clk. After release with mode=0 and en=1, dout = channel 0 (16'h1000).
- Generics: WIDTH=32 and CHANNELS=16 with random din and random sel/en/mode. Check against a cycle model for 2000 cycles.

Source files
------------

// File: rtl/bus_select_reg.sv
// Registered N-channel bus selector with a latched select, capture enable,
// out-of-range flagging and an auto-incrementing scan mode for sweeping sources.
module bus_select_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_ld,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_sel,
    output logic                      dout_valid,
    output logic                      sel_err,
    output logic                      scan_wrap
);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_reg_q, sel_reg_d;
    logic [SEL_W-1:0]   scan_ptr_q, scan_ptr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [SEL_W-1:0]   dout_sel_q, dout_sel_d;
    logic               dout_valid_q, dout_valid_d;
    logic               sel_err_q, sel_err_d;
    logic               scan_wrap_q, scan_wrap_d;

    logic [SEL_W-1:0]   idx;
    logic               idx_oor;
    logic               idx_last;
    logic [WIDTH-1:0]   chan_data;

    always_comb begin
        if (sel_ld) begin
            idx = sel;
        end else if (state_q == ST_SCAN) begin
            idx = scan_ptr_q;
        end else begin
            idx = sel_reg_q;
        end
        idx_oor  = ({1'b0, idx} >= NUM_CH);
        idx_last = (idx == LAST_IDX);
    end

    // Decoded mux: an index with no matching channel leaves the data at zero.
    always_comb begin
        chan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                chan_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_reg_d    = sel_reg_q;
        scan_ptr_d   = scan_ptr_q;
        dout_d       = dout_q;
        dout_sel_d   = dout_sel_q;
        dout_valid_d = 1'b0;
        sel_err_d    = sel_err_q;
        scan_wrap_d  = 1'b0;

        if (state_q == ST_DIRECT) begin
            if (sel_ld) begin
                sel_reg_d = sel;
            end
            if (mode) begin
                state_d    = ST_SCAN;
                scan_ptr_d = idx;
            end else if (en) begin
                dout_d       = chan_data;
                dout_sel_d   = idx;
                dout_valid_d = 1'b1;
                sel_err_d    = idx_oor;
            end
        end else begin
            // Mode-change edges never capture; they only switch state.
            if (!mode) begin
                state_d = ST_DIRECT;
                if (sel_ld) begin
                    scan_ptr_d = sel;
                end
            end else if (en) begin
                dout_d       = chan_data;
                dout_sel_d   = idx;
                dout_valid_d = 1'b1;
                sel_err_d    = idx_oor;
                scan_wrap_d  = idx_last;
                scan_ptr_d   = (idx_oor || idx_last) ? '0 : idx + 1'b1;
            end else if (sel_ld) begin
                scan_ptr_d = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DIRECT;
            sel_reg_q    <= '0;
            scan_ptr_q   <= '0;
            dout_q       <= '0;
            dout_sel_q   <= '0;
            dout_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
            scan_wrap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_reg_q    <= sel_reg_d;
            scan_ptr_q   <= scan_ptr_d;
            dout_q       <= dout_d;
            dout_sel_q   <= dout_sel_d;
            dout_valid_q <= dout_valid_d;
            sel_err_q    <= sel_err_d;
            scan_wrap_q  <= scan_wrap_d;
        end
    end

    assign dout       = dout_q;
    assign dout_sel   = dout_sel_q;
    assign dout_valid = dout_valid_q;
    assign sel_err    = sel_err_q;
    assign scan_wrap  = scan_wrap_q;

endmodule

// File: tb/tb_bus_select_reg.sv
// Scoreboard bench for bus_select_reg: three instances (8x16, 5x16, 16x32)
// driven by directed steps, plus a randomised run against a cycle model.
module tb_bus_select_reg;

    typedef struct {
        logic [31:0] dout;
        logic [7:0]  dsel;
        logic        valid;
        logic        err;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [127:0] din8  = '0;
    logic [2:0]   sel8  = '0;
    logic         ld8   = 1'b0, mode8 = 1'b0, en8 = 1'b0;
    logic [15:0]  dout8;
    logic [2:0]   dsel8;
    logic         v8, e8, w8;

    logic [79:0]  din5  = '0;
    logic [2:0]   sel5  = '0;
    logic         ld5   = 1'b0, mode5 = 1'b0, en5 = 1'b0;
    logic [15:0]  dout5;
    logic [2:0]   dsel5;
    logic         v5, e5, w5;

    logic [511:0] din32  = '0;
    logic [3:0]   sel32  = '0;
    logic         ld32   = 1'b0, mode32 = 1'b0, en32 = 1'b0;
    logic [31:0]  dout32;
    logic [3:0]   dsel32;
    logic         v32, e32, w32;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_select_reg #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .sel(sel8), .sel_ld(ld8), .mode(mode8), .en(en8),
        .dout(dout8), .dout_sel(dsel8), .dout_valid(v8), .sel_err(e8), .scan_wrap(w8)
    );

    bus_select_reg #(.WIDTH(16), .CHANNELS(5), .SEL_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .din(din5), .sel(sel5), .sel_ld(ld5), .mode(mode5), .en(en5),
        .dout(dout5), .dout_sel(dsel5), .dout_valid(v5), .sel_err(e5), .scan_wrap(w5)
    );

    bus_select_reg #(.WIDTH(32), .CHANNELS(16), .SEL_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .din(din32), .sel(sel32), .sel_ld(ld32), .mode(mode32), .en(en32),
        .dout(dout32), .dout_sel(dsel32), .dout_valid(v32), .sel_err(e32), .scan_wrap(w32)
    );

    task automatic pushExp(input logic [31:0] d, input logic [7:0] s,
                           input logic v, input logic e, input logic w);
        exp_t x;
        x.dout = d; x.dsel = s; x.valid = v; x.err = e; x.wrap = w;
        exp_q.push_back(x);
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] expv);
        total++;
        assert (act === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, fld, act, expv);
        end
    endtask

    task automatic checkOutput(input int which, input string tag);
        exp_t e;
        exp_t a;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        if (which == 0) begin
            a.dout = 32'(dout8);  a.dsel = 8'(dsel8);  a.valid = v8;  a.err = e8;  a.wrap = w8;
        end else if (which == 1) begin
            a.dout = 32'(dout5);  a.dsel = 8'(dsel5);  a.valid = v5;  a.err = e5;  a.wrap = w5;
        end else begin
            a.dout = dout32;      a.dsel = 8'(dsel32); a.valid = v32; a.err = e32; a.wrap = w32;
        end
        cmp(tag, "dout",       a.dout,         e.dout);
        cmp(tag, "dout_sel",   32'(a.dsel),    32'(e.dsel));
        cmp(tag, "dout_valid", 32'(a.valid),   32'(e.valid));
        cmp(tag, "sel_err",    32'(a.err),     32'(e.err));
        cmp(tag, "scan_wrap",  32'(a.wrap),    32'(e.wrap));
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] s,
                                 input logic ld, input logic md, input logic e);
        if (which == 0) begin
            sel8 = s[2:0]; ld8 = ld; mode8 = md; en8 = e;
        end else begin
            sel5 = s[2:0]; ld5 = ld; mode5 = md; en5 = e;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill8(input logic [15:0] base);
        for (int k = 0; k < 8; k++) din8[k*16 +: 16] = base + 16'(k);
    endtask

    // Reference model state for the randomised 16x32 instance.
    logic        m_scan;
    logic [3:0]  m_selreg, m_ptr, m_idx, m_dsel;
    logic [31:0] m_dout;
    logic        m_v, m_w;

    initial begin
        for (int k = 0; k < 5; k++) din5[k*16 +: 16] = 16'h1000 + 16'(k);
        fill8(16'h1000);

        // Reset state
        #2;
        pushExp(0, 0, 0, 0, 0); checkOutput(0, "reset8");
        pushExp(0, 0, 0, 0, 0); checkOutput(1, "reset5");
        @(negedge clk);
        rst = 1'b0;

        // DIRECT sweep over every channel
        for (int s = 0; s < 8; s++) begin
            applyStimulus(0, 8'(s), 1, 0, 1);
            pushExp(32'h1000 + 32'(s), 8'(s), 1, 0, 0);
            step();
            checkOutput(0, $sformatf("sweep%0d", s));
        end
        applyStimulus(0, 0, 0, 0, 0);
        pushExp(32'h1007, 7, 0, 0, 0); step(); checkOutput(0, "sweep_pulse");

        // Hold with en=0 while din and sel wander
        applyStimulus(0, 5, 1, 0, 1);
        pushExp(32'h1005, 5, 1, 0, 0); step(); checkOutput(0, "hold_cap");
        fill8(16'h2000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'(i + 1), 0, 0, 0);
            pushExp(32'h1005, 5, 0, 0, 0); step(); checkOutput(0, $sformatf("hold%0d", i));
        end
        applyStimulus(0, 2, 0, 0, 1);
        pushExp(32'h2005, 5, 1, 0, 0); step(); checkOutput(0, "hold_selreg");
        fill8(16'h1000);

        // SCAN entry with same-edge load, then sweep across the wrap
        applyStimulus(0, 6, 1, 1, 1);
        pushExp(32'h2005, 5, 0, 0, 0); step(); checkOutput(0, "scan_entry");
        applyStimulus(0, 0, 0, 1, 1);
        pushExp(32'h1006, 6, 1, 0, 0); step(); checkOutput(0, "scan6");
        pushExp(32'h1007, 7, 1, 0, 1); step(); checkOutput(0, "scan7");
        pushExp(32'h1000, 0, 1, 0, 0); step(); checkOutput(0, "scan0");
        pushExp(32'h1001, 1, 1, 0, 0); step(); checkOutput(0, "scan1");
        pushExp(32'h1002, 2, 1, 0, 0); step(); checkOutput(0, "scan2");

        // Asynchronous reset between edges mid-scan
        #2;
        rst = 1'b1;
        #1;
        pushExp(0, 0, 0, 0, 0); checkOutput(0, "async_rst");
        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        pushExp(32'h1000, 0, 1, 0, 0); step(); checkOutput(0, "post_rst");
        applyStimulus(0, 0, 0, 0, 0);

        // Out-of-range handling on the 5-channel instance
        applyStimulus(1, 6, 1, 0, 1);
        pushExp(0, 6, 1, 1, 0); step(); checkOutput(1, "oor_direct");
        applyStimulus(1, 2, 1, 0, 1);
        pushExp(32'h1002, 2, 1, 0, 0); step(); checkOutput(1, "oor_clear");
        applyStimulus(1, 7, 1, 1, 1);
        pushExp(32'h1002, 2, 0, 0, 0); step(); checkOutput(1, "oor_scan_entry");
        applyStimulus(1, 0, 0, 1, 1);
        pushExp(0, 7, 1, 1, 0); step(); checkOutput(1, "oor_scan");
        pushExp(32'h1000, 0, 1, 0, 0); step(); checkOutput(1, "oor_scan_next");
        applyStimulus(1, 4, 1, 1, 1);
        pushExp(32'h1004, 4, 1, 0, 1); step(); checkOutput(1, "wrap5");
        applyStimulus(1, 0, 0, 1, 1);
        pushExp(32'h1000, 0, 1, 0, 0); step(); checkOutput(1, "wrap5_next");
        applyStimulus(1, 0, 0, 0, 1);
        pushExp(32'h1000, 0, 0, 0, 0); step(); checkOutput(1, "scan_exit");
        applyStimulus(1, 0, 0, 0, 0);

        // Randomised 16x32 run against the cycle model
        m_scan = 1'b0; m_selreg = '0; m_ptr = '0; m_dsel = '0;
        m_dout = '0;   m_v = 1'b0;    m_w = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 16; k++) din32[k*32 +: 32] = $urandom();
            sel32 = 4'($urandom_range(0, 15));
            ld32  = ($urandom_range(0, 3) == 0);
            en32  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode32 = ~mode32;
            if (mode32 != m_scan) ld32 = 1'b0;

            m_v = 1'b0;
            m_w = 1'b0;
            if (mode32 != m_scan) begin
                if (mode32) m_ptr = m_selreg;
                m_scan = mode32;
            end else begin
                m_idx = ld32 ? sel32 : (m_scan ? m_ptr : m_selreg);
                if (!m_scan && ld32) m_selreg = sel32;
                if (en32) begin
                    m_dout = din32[m_idx*32 +: 32];
                    m_dsel = m_idx;
                    m_v    = 1'b1;
                    if (m_scan) begin
                        m_w   = (m_idx == 4'd15);
                        m_ptr = m_idx + 4'd1;
                    end
                end else if (m_scan && ld32) begin
                    m_ptr = sel32;
                end
            end
            pushExp(m_dout, 8'(m_dsel), m_v, 1'b0, m_w);
            step();
            checkOutput(2, $sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
